awp_host: RTL and testbench

CPU-side initiator for the AWP coprocessor. It accepts a decoded FPU instruction from the CPU sequencer and raises efp toward the AWP. While the AWP runs, it answers the AWP's memory-read requests (sr_fp/read_fp with the ok$ reply) and serves r1–r3 reads and writes (rlp_fp, lpa, lpb, s_fp). It also latches flags on ustr0_fp, collects fi0–fi3 into sticky interrupt requests and closes the operation on ekc_fp. A watchdog aborts the operation if the AWP hangs.

---
 rtl/awp_pkg.sv | 28 ++
 rtl/awp_host_edge.sv | 19 +
 rtl/awp_host.sv | 197 +++++++++++++++++++
 tb/tb_awp_host.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/awp_pkg.sv
// Shared types and constants for the AWP coprocessor host interface.
// Bit indices follow the big-endian [0:N] numbering of the AWP buses.
package awp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_MEMRD,
    ST_OKP,
    ST_FIN
  } state_t;

  localparam logic [1:0] LP_R1 = 2'b01;
  localparam logic [1:0] LP_R2 = 2'b10;
  localparam logic [1:0] LP_R3 = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_M = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  localparam int FI_0 = 0;
  localparam int FI_1 = 1;
  localparam int FI_2 = 2;
  localparam int FI_3 = 3;
  localparam int NFI  = 4;

endpackage

// File: rtl/awp_host_edge.sv
// Rising-edge detector: the previous level is registered and the
// pulse is high in the first cycle the input is seen high.
module awp_host_edge (
  input  logic clk_sys,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) prev_reg <= 1'b0;
    else     prev_reg <= sig;
  end

  assign rise = sig & ~prev_reg;

endmodule

// File: rtl/awp_host.sv
// CPU-side initiator for the AWP coprocessor: dispatches an FPU operation,
// serves AWP memory reads and register/flag traffic, and guards with a watchdog.
module awp_host
  import awp_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int AW      = 16
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          start,
  input  logic [7:9]    ir,
  input  logic [0:AW-1] ea,
  input  logic [0:15]   r1,
  input  logic [0:15]   r2,
  input  logic [0:15]   r3,
  output logic          busy,
  output logic          done,
  output logic          tout,
  output logic          efp,
  output logic [0:15]   w,
  output logic          ok$,
  input  logic [0:15]   zp,
  input  logic          sr_fp,
  input  logic          read_fp,
  input  logic          rlp_fp,
  input  logic          lpa,
  input  logic          lpb,
  input  logic          s_fp,
  input  logic          ustr0_fp,
  input  logic          strob_fp,
  input  logic          ekc_fp,
  input  logic [0:3]    fi,
  output logic          mem_req,
  output logic [0:AW-1] mem_addr,
  input  logic          mem_ack,
  input  logic [0:15]   mem_data,
  output logic          reg_we,
  output logic [0:1]    reg_sel,
  output logic [0:15]   reg_data,
  output logic          flags_we,
  output logic [0:3]    flags,
  output logic [0:3]    int_req,
  input  logic [0:3]    int_ack
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t          state_reg, state_next;
  logic [0:AW-1]   addr_reg;
  logic [0:15]     buf_reg;
  logic [WDW-1:0]  wd_reg;
  logic            abort_reg, abort_next;
  logic            reg_we_reg, flags_we_reg;
  logic [0:1]      reg_sel_reg;
  logic [0:15]     reg_data_reg;
  logic [0:3]      flags_reg, int_req_reg, fi_set;
  logic            active, wd_expire, sr_rise, strob_rise;
  logic            read_done, reg_wr, flag_wr;
  logic [1:0]      lp_sel;
  logic            unused_ir;

  awp_host_edge u_sr_edge    (.clk_sys(clk_sys), .rst(rst), .sig(sr_fp),    .rise(sr_rise));
  awp_host_edge u_strob_edge (.clk_sys(clk_sys), .rst(rst), .sig(strob_fp), .rise(strob_rise));

  assign active    = (state_reg == ST_RUN) || (state_reg == ST_MEMRD) || (state_reg == ST_OKP);
  assign wd_expire = (wd_reg == WDW'(TIMEOUT - 1));
  assign lp_sel    = {lpa, lpb};
  assign read_done = (state_reg == ST_MEMRD) && (state_next == ST_OKP);
  assign reg_wr    = active && strob_rise && rlp_fp && s_fp;
  assign flag_wr   = active && strob_rise && ustr0_fp;
  assign fi_set    = {fi[FI_0], fi[FI_1], fi[FI_2], fi[FI_3]} & {NFI{active & ekc_fp}};
  assign unused_ir = ^ir;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // ekc_fp outranks the watchdog, which outranks normal progress.
  always_comb begin
    state_next = state_reg;
    abort_next = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN, ST_MEMRD, ST_OKP: begin
        if (ekc_fp) begin
          state_next = ST_FIN;
        end else if (wd_expire) begin
          state_next = ST_FIN;
          abort_next = 1'b1;
        end else if (state_reg == ST_RUN) begin
          if (sr_rise) state_next = ST_MEMRD;
        end else if (state_reg == ST_MEMRD) begin
          if (mem_ack) state_next = ST_OKP;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    efp     = 1'b0;
    mem_req = 1'b0;
    ok$     = 1'b0;
    done    = 1'b0;
    tout    = 1'b0;
    case (state_reg)
      ST_RUN:   begin busy = 1'b1; efp = 1'b1; end
      ST_MEMRD: begin busy = 1'b1; efp = 1'b1; mem_req = 1'b1; end
      ST_OKP:   begin busy = 1'b1; efp = 1'b1; ok$ = 1'b1; end
      ST_FIN:   begin done = 1'b1; tout = abort_reg; end
      default:  ;
    endcase
  end

  always_comb begin
    w = 16'h0000;
    if (read_fp) begin
      w = buf_reg;
    end else if (rlp_fp && !s_fp) begin
      case (lp_sel)
        LP_R1:   w = r1;
        LP_R2:   w = r2;
        LP_R3:   w = r3;
        default: w = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      buf_reg   <= '0;
      wd_reg    <= '0;
      abort_reg <= 1'b0;
    end else begin
      abort_reg <= abort_next;
      if (state_reg == ST_IDLE && start) begin
        addr_reg <= ea;
        wd_reg   <= '0;
      end else begin
        if (active) wd_reg <= wd_reg + WDW'(1);
        if (read_done) begin
          buf_reg  <= mem_data;
          addr_reg <= addr_reg + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      reg_we_reg   <= 1'b0;
      reg_sel_reg  <= '0;
      reg_data_reg <= '0;
      flags_we_reg <= 1'b0;
      flags_reg    <= '0;
    end else begin
      reg_we_reg   <= reg_wr;
      flags_we_reg <= flag_wr;
      if (reg_wr) begin
        reg_sel_reg  <= lp_sel;
        reg_data_reg <= zp;
      end
      if (flag_wr) begin
        flags_reg[FLAG_Z] <= zp[FLAG_Z];
        flags_reg[FLAG_M] <= zp[FLAG_M];
        flags_reg[FLAG_V] <= zp[FLAG_V];
        flags_reg[FLAG_C] <= zp[FLAG_C];
      end
    end
  end

  // A new request always beats a same-cycle acknowledge of that bit.
  generate
    for (genvar gi = 0; gi < NFI; gi++) begin : g_int
      always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) int_req_reg[gi] <= 1'b0;
        else     int_req_reg[gi] <= (int_req_reg[gi] & ~int_ack[gi]) | fi_set[gi];
      end
    end
  endgenerate

  assign mem_addr = addr_reg;
  assign reg_we   = reg_we_reg;
  assign reg_sel  = reg_sel_reg;
  assign reg_data = reg_data_reg;
  assign flags_we = flags_we_reg;
  assign flags    = flags_reg;
  assign int_req  = int_req_reg;

endmodule

// File: tb/tb_awp_host.sv
// Self-checking bench for awp_host: directed scenarios plus randomized
// operations checked against a transaction-level model of the host.
module tb_awp_host;

  localparam int TO = 64;
  localparam int AW = 16;

  logic          clk_sys = 1'b0;
  logic          rst, start;
  logic [7:9]    ir;
  logic [0:AW-1] ea;
  logic [0:15]   r1, r2, r3, zp, mem_data, w, reg_data;
  logic          busy, done, tout, efp, ok_s, mem_req, mem_ack;
  logic          sr_fp, read_fp, rlp_fp, lpa, lpb, s_fp, ustr0_fp, strob_fp, ekc_fp;
  logic [0:3]    fi, flags, int_req, int_ack;
  logic [0:AW-1] mem_addr;
  logic          reg_we, flags_we;
  logic [0:1]    reg_sel;

  always #5 clk_sys = ~clk_sys;

  awp_host #(.TIMEOUT(TO), .AW(AW)) dut (
    .clk_sys(clk_sys), .rst(rst), .start(start), .ir(ir), .ea(ea),
    .r1(r1), .r2(r2), .r3(r3), .busy(busy), .done(done), .tout(tout),
    .efp(efp), .w(w), .ok$(ok_s), .zp(zp), .sr_fp(sr_fp), .read_fp(read_fp),
    .rlp_fp(rlp_fp), .lpa(lpa), .lpb(lpb), .s_fp(s_fp), .ustr0_fp(ustr0_fp),
    .strob_fp(strob_fp), .ekc_fp(ekc_fp), .fi(fi), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_data(reg_data),
    .flags_we(flags_we), .flags(flags), .int_req(int_req), .int_ack(int_ack)
  );

  int total = 0;
  int bad   = 0;
  int op_cyc;

  // reference model state
  logic [15:0] m_addr, m_buf;
  logic [3:0]  m_int, m_flags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    op_cyc++;
  endtask

  task automatic dispatch(input logic [15:0] a);
    ea = a;
    ir = 3'($urandom);
    start = 1'b1;
    op_cyc = 0;
    tick();
    start = 1'b0;
    m_addr = a;
    chk("busy_on", busy, 1);
    chk("efp_on", efp, 1);
  endtask

  task automatic do_read(input logic [15:0] d, input bit hold);
    int n;
    sr_fp = 1'b1;
    tick();
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, m_addr);
    if (!hold) sr_fp = 1'b0;
    n = $urandom_range(0, 2);
    repeat (n) begin
      tick();
      chk("mem_req_hold", mem_req, 1);
    end
    mem_data = d;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_data = 16'($urandom);
    chk("ok_pulse", ok_s, 1);
    chk("req_drop", mem_req, 0);
    m_buf = d;
    m_addr = m_addr + 16'd1;
    read_fp = 1'b1;
    #1;
    chk("w_read", w, m_buf);
    tick();
    read_fp = 1'b0;
    chk("ok_once", ok_s, 0);
    tick();
    chk("no_reread", mem_req, 0);
    sr_fp = 1'b0;
    tick();
  endtask

  task automatic reg_read(input logic [1:0] sel, input bit rd, input bit s,
                          input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3);
    logic [15:0] exp;
    r1 = v1; r2 = v2; r3 = v3;
    {lpa, lpb} = sel;
    rlp_fp = 1'b1;
    s_fp = s;
    read_fp = rd;
    if (rd)          exp = m_buf;
    else if (s)      exp = 16'h0000;
    else if (sel == 2'd1) exp = v1;
    else if (sel == 2'd2) exp = v2;
    else if (sel == 2'd3) exp = v3;
    else             exp = 16'h0000;
    #1;
    chk("w_mux", w, exp);
    tick();
    rlp_fp = 1'b0; s_fp = 1'b0; read_fp = 1'b0; lpa = 1'b0; lpb = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [15:0] d);
    {lpa, lpb} = sel;
    rlp_fp = 1'b1;
    s_fp = 1'b1;
    zp = d;
    strob_fp = 1'b1;
    tick();
    chk("reg_we", reg_we, 1);
    chk("reg_sel", reg_sel, sel);
    chk("reg_data", reg_data, d);
    chk("no_flag_we", flags_we, 0);
    strob_fp = 1'b0; rlp_fp = 1'b0; s_fp = 1'b0; lpa = 1'b0; lpb = 1'b0;
    zp = 16'($urandom);
    tick();
    chk("reg_we_once", reg_we, 0);
  endtask

  task automatic flag_write(input logic [15:0] d);
    ustr0_fp = 1'b1;
    zp = d;
    strob_fp = 1'b1;
    tick();
    m_flags = d[15:12];
    chk("flags_we", flags_we, 1);
    chk("flags", flags, m_flags);
    chk("no_reg_we", reg_we, 0);
    strob_fp = 1'b0; ustr0_fp = 1'b0;
    zp = 16'($urandom);
    tick();
    chk("flags_we_once", flags_we, 0);
    chk("flags_hold", flags, m_flags);
  endtask

  task automatic finish(input logic [3:0] f, input logic [3:0] ack);
    fi = f;
    int_ack = ack;
    ekc_fp = 1'b1;
    tick();
    ekc_fp = 1'b0; fi = 4'h0; int_ack = 4'h0;
    m_int = (m_int & ~ack) | f;
    chk("done", done, 1);
    chk("tout_none", tout, 0);
    chk("busy_fin", busy, 0);
    chk("efp_fin", efp, 0);
    chk("mem_req_fin", mem_req, 0);
    chk("int_req", int_req, m_int);
    tick();
    chk("done_once", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic ack_only(input logic [3:0] ack);
    int_ack = ack;
    tick();
    int_ack = 4'h0;
    m_int = m_int & ~ack;
    chk("int_ack", int_req, m_int);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ir = '0; ea = '0; r1 = '0; r2 = '0; r3 = '0; zp = '0;
    sr_fp = 1'b0; read_fp = 1'b0; rlp_fp = 1'b0; lpa = 1'b0; lpb = 1'b0; s_fp = 1'b0;
    ustr0_fp = 1'b0; strob_fp = 1'b0; ekc_fp = 1'b0; fi = '0; mem_ack = 1'b0;
    mem_data = '0; int_ack = '0;
    m_addr = '0; m_buf = '0; m_int = '0; m_flags = '0; op_cyc = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tout", tout, 0);
    chk("rst_efp", efp, 0);
    chk("rst_w", w, 0);
    chk("rst_ok", ok_s, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_flags", flags, 0);
    chk("rst_int_req", int_req, 0);
    rst = 1'b0;
    tick();

    // dispatch and completion: efp high in cycles 1..20
    dispatch(16'h1000);
    while (op_cyc < 20) begin
      chk("efp_run", efp, 1);
      tick();
    end
    chk("efp_c20", efp, 1);
    finish(4'h0, 4'h0);
    chk("efp_after", efp, 0);
    $display("op dispatch ea=1000 cycles=20");

    // three memory reads
    dispatch(16'h1000);
    do_read(16'hAAAA, 1'b0);
    do_read(16'h5555, 1'b1);
    do_read(16'h1234, 1'b0);
    finish(4'h0, 4'h0);
    $display("op reads ea=1000 count=3");

    // address wrap
    dispatch(16'hFFFF);
    do_read(16'h0001, 1'b0);
    do_read(16'h0002, 1'b0);
    finish(4'h0, 4'h0);
    $display("op wrap ea=ffff count=2");

    // register and flag traffic, interrupts
    dispatch(16'h0040);
    reg_read(2'b10, 1'b0, 1'b0, 16'h1111, 16'hBEEF, 16'h3333);
    reg_write(2'b10, 16'h0F0F);
    flag_write(16'hA000);
    finish(4'b0100, 4'h0);
    $display("op regs int_req=%b", int_req);
    dispatch(16'h0041);
    finish(4'b0100, 4'b0100);
    ack_only(4'b0100);
    $display("op int_ack int_req=%b", int_req);

    // watchdog abort with an outstanding read
    dispatch(16'h0200);
    sr_fp = 1'b1;
    tick();
    sr_fp = 1'b0;
    while (op_cyc < TO) tick();
    chk("wd_last_req", mem_req, 1);
    chk("wd_last_efp", efp, 1);
    tick();
    chk("wd_done", done, 1);
    chk("wd_tout", tout, 1);
    chk("wd_efp", efp, 0);
    chk("wd_busy", busy, 0);
    chk("wd_mem_req", mem_req, 0);
    chk("wd_int_req", int_req, m_int);
    tick();
    chk("wd_done_once", done, 0);
    chk("wd_tout_once", tout, 0);
    mem_ack = 1'b1;
    mem_data = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_ok", ok_s, 0);
    chk("late_ack_busy", busy, 0);
    $display("op watchdog abort at cycle %0d", TO);

    // ekc_fp in the expiry cycle wins
    dispatch(16'h0300);
    while (op_cyc < TO) tick();
    finish(4'h0, 4'h0);
    $display("op ekc_at_expiry no tout");

    // ekc_fp during an outstanding read abandons it
    dispatch(16'h0400);
    sr_fp = 1'b1;
    tick();
    sr_fp = 1'b0;
    chk("abandon_req", mem_req, 1);
    finish(4'h0, 4'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("abandon_ok", ok_s, 0);
    dispatch(16'h0500);
    do_read(16'h7777, 1'b0);
    reg_read(2'b00, 1'b1, 1'b0, 16'h1, 16'h2, 16'h3);
    finish(4'h0, 4'h0);
    $display("op abandon then normal dispatch");

    // randomized operations
    for (int op = 0; op < 15; op++) begin
      logic [15:0] a;
      int nact;
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      nact = $urandom_range(1, 5);
      dispatch(a);
      for (int k = 0; k < nact; k++) begin
        case ($urandom_range(0, 4))
          0: do_read(16'($urandom), 1'($urandom));
          1: reg_read(2'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                      16'($urandom), 16'($urandom), 16'($urandom));
          2: reg_write(2'($urandom), 16'($urandom));
          3: flag_write(16'($urandom));
          default: begin
            ea = 16'($urandom);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("start_busy_ignored", busy, 1);
          end
        endcase
      end
      finish(4'($urandom), 4'($urandom));
      $display("op rand %0d ea=%h acts=%0d int_req=%b", op, a, nact, int_req);
    end

    // asynchronous reset mid-operation
    dispatch(16'h0600);
    finish(4'b1011, 4'h0);
    dispatch(16'h0700);
    flag_write(16'hF000);
    #3;
    rst = 1'b1;
    #1;
    m_int = '0; m_flags = '0; m_buf = '0;
    chk("arst_efp", efp, 0);
    chk("arst_busy", busy, 0);
    chk("arst_int_req", int_req, m_int);
    chk("arst_flags", flags, m_flags);
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    tick();
    chk("arst_idle", busy, 0);
    $display("op async reset mid-operation");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
